// File: rtl/axi_crossbar_rresp_if.sv
// Bundle of the R-return path signals: reply commands, per-master R channels,
// slave-side R output and completion events.
interface axi_crossbar_rresp_if #(
    parameter int M_COUNT     = 4,
    parameter int DATA_WIDTH  = 32,
    parameter int ID_WIDTH    = 8,
    parameter int RUSER_WIDTH = 1
);
    logic [ID_WIDTH-1:0]             s_rc_id;
    logic [7:0]                      s_rc_len;
    logic                            s_rc_decerr;
    logic                            s_rc_valid;
    logic                            s_rc_ready;

    logic [M_COUNT*ID_WIDTH-1:0]     int_rid;
    logic [M_COUNT*DATA_WIDTH-1:0]   int_rdata;
    logic [M_COUNT*2-1:0]            int_rresp;
    logic [M_COUNT-1:0]              int_rlast;
    logic [M_COUNT*RUSER_WIDTH-1:0]  int_ruser;
    logic [M_COUNT-1:0]              int_rvalid;
    logic [M_COUNT-1:0]              int_rready;

    logic [ID_WIDTH-1:0]             s_axi_rid;
    logic [DATA_WIDTH-1:0]           s_axi_rdata;
    logic [1:0]                      s_axi_rresp;
    logic                            s_axi_rlast;
    logic [RUSER_WIDTH-1:0]          s_axi_ruser;
    logic                            s_axi_rvalid;
    logic                            s_axi_rready;

    logic [ID_WIDTH-1:0]             m_cpl_id;
    logic                            m_cpl_valid;

    // The return-path block itself
    modport slave (
        input  s_rc_id, s_rc_len, s_rc_decerr, s_rc_valid,
        output s_rc_ready,
        input  int_rid, int_rdata, int_rresp, int_rlast, int_ruser, int_rvalid,
        output int_rready,
        output s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_ruser, s_axi_rvalid,
        input  s_axi_rready,
        output m_cpl_id, m_cpl_valid
    );

    // Surrounding crossbar logic
    modport master (
        output s_rc_id, s_rc_len, s_rc_decerr, s_rc_valid,
        input  s_rc_ready,
        output int_rid, int_rdata, int_rresp, int_rlast, int_ruser, int_rvalid,
        input  int_rready,
        input  s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_ruser, s_axi_rvalid,
        output s_axi_rready,
        input  m_cpl_id, m_cpl_valid
    );
endinterface

// File: rtl/axi_crossbar_rresp.sv
// Read-response return path: burst-locked round-robin merge of per-master R
// channels and a local decode-error responder, with burst completion events.
module axi_crossbar_rresp #(
    parameter int M_COUNT      = 4,
    parameter int DATA_WIDTH   = 32,
    parameter int ID_WIDTH     = 8,
    parameter int RUSER_ENABLE = 0,
    parameter int RUSER_WIDTH  = 1
) (
    input logic clk,
    input logic rst,
    axi_crossbar_rresp_if.slave bus
);
    localparam int N  = M_COUNT + 1;
    localparam int GW = $clog2(N);

    typedef enum logic {DEC_IDLE, DEC_ACTIVE} dec_state_t;

    dec_state_t          dec_state;
    logic [ID_WIDTH-1:0] dec_id;
    logic [7:0]          dec_len;
    logic [7:0]          dec_cnt;

    logic [N-1:0]                  req;
    logic [N-1:0][ID_WIDTH-1:0]    src_id;
    logic [N-1:0][DATA_WIDTH-1:0]  src_data;
    logic [N-1:0][1:0]             src_resp;
    logic [N-1:0]                  src_last;
    logic [N-1:0][RUSER_WIDTH-1:0] src_user;

    logic          lock;
    logic [GW-1:0] grant, last_grant, rr_sel, rr_cand;
    logic          rr_found;
    logic          out_free, acc, dec_acc, out_dec, cpl_fire;

    // Source M_COUNT is the decode-error responder; it never carries user bits
    for (genvar i = 0; i < M_COUNT; i++) begin : g_src
        assign req[i]      = bus.int_rvalid[i];
        assign src_id[i]   = bus.int_rid[i*ID_WIDTH +: ID_WIDTH];
        assign src_data[i] = bus.int_rdata[i*DATA_WIDTH +: DATA_WIDTH];
        assign src_resp[i] = bus.int_rresp[i*2 +: 2];
        assign src_last[i] = bus.int_rlast[i];
        assign src_user[i] = bus.int_ruser[i*RUSER_WIDTH +: RUSER_WIDTH]
                             & {RUSER_WIDTH{RUSER_ENABLE != 0}};
        assign bus.int_rready[i] = lock && out_free && (grant == GW'(i));
    end

    assign req[M_COUNT]      = (dec_state == DEC_ACTIVE);
    assign src_id[M_COUNT]   = dec_id;
    assign src_data[M_COUNT] = '0;
    assign src_resp[M_COUNT] = 2'b11;
    assign src_last[M_COUNT] = (dec_cnt == dec_len);
    assign src_user[M_COUNT] = '0;

    assign out_free = !bus.s_axi_rvalid || bus.s_axi_rready;
    assign acc      = lock && out_free && req[grant];
    assign dec_acc  = acc && (grant == GW'(M_COUNT));
    assign cpl_fire = bus.s_axi_rvalid && bus.s_axi_rready && bus.s_axi_rlast && !out_dec;

    // First requester after the previous winner, wrapping through all N sources
    always_comb begin
        rr_sel   = '0;
        rr_found = 1'b0;
        rr_cand  = '0;
        for (int k = 1; k <= N; k++) begin
            rr_cand = GW'((int'(last_grant) + k) % N);
            if (!rr_found && req[rr_cand]) begin
                rr_found = 1'b1;
                rr_sel   = rr_cand;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock       <= 1'b0;
            grant      <= '0;
            last_grant <= GW'(M_COUNT);
        end else if (!lock) begin
            if (rr_found) begin
                lock       <= 1'b1;
                grant      <= rr_sel;
                last_grant <= rr_sel;
            end
        end else if (acc && src_last[grant]) begin
            lock <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dec_state      <= DEC_IDLE;
            dec_id         <= '0;
            dec_len        <= '0;
            dec_cnt        <= '0;
            bus.s_rc_ready <= 1'b0;
        end else begin
            bus.s_rc_ready <= 1'b0;
            case (dec_state)
                DEC_IDLE: if (bus.s_rc_valid && bus.s_rc_decerr) begin
                    dec_id         <= bus.s_rc_id;
                    dec_len        <= bus.s_rc_len;
                    dec_cnt        <= '0;
                    bus.s_rc_ready <= 1'b1;
                    dec_state      <= DEC_ACTIVE;
                end
                DEC_ACTIVE: if (dec_acc) begin
                    dec_cnt <= dec_cnt + 8'd1;
                    if (dec_cnt == dec_len) dec_state <= DEC_IDLE;
                end
                default: dec_state <= DEC_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.s_axi_rvalid <= 1'b0;
            bus.s_axi_rid    <= '0;
            bus.s_axi_rdata  <= '0;
            bus.s_axi_rresp  <= '0;
            bus.s_axi_rlast  <= 1'b0;
            bus.s_axi_ruser  <= '0;
            out_dec          <= 1'b0;
        end else if (acc) begin
            bus.s_axi_rvalid <= 1'b1;
            bus.s_axi_rid    <= src_id[grant];
            bus.s_axi_rdata  <= src_data[grant];
            bus.s_axi_rresp  <= src_resp[grant];
            bus.s_axi_rlast  <= src_last[grant];
            bus.s_axi_ruser  <= src_user[grant];
            out_dec          <= (grant == GW'(M_COUNT));
        end else if (bus.s_axi_rready) begin
            bus.s_axi_rvalid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.m_cpl_valid <= 1'b0;
            bus.m_cpl_id    <= '0;
        end else begin
            bus.m_cpl_valid <= cpl_fire;
            if (cpl_fire) bus.m_cpl_id <= bus.s_axi_rid;
        end
    end
endmodule

// File: tb/tb_axi_crossbar_rresp.sv
// Directed bench for the crossbar read-response return path.
module tb_axi_crossbar_rresp;
    localparam int M = 4, DW = 32, IW = 8, UW = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axi_crossbar_rresp_if #(.M_COUNT(M), .DATA_WIDTH(DW), .ID_WIDTH(IW), .RUSER_WIDTH(UW)) bus ();

    axi_crossbar_rresp #(.M_COUNT(M), .DATA_WIDTH(DW), .ID_WIDTH(IW),
                         .RUSER_ENABLE(0), .RUSER_WIDTH(UW)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    typedef struct { logic [IW-1:0] id; logic [DW-1:0] data; logic last; } src_beat_t;
    typedef struct { logic [IW-1:0] id; logic [DW-1:0] data; logic [1:0] resp; logic last; int cyc; } obs_t;
    typedef struct { logic [IW-1:0] id; int cyc; } cpl_t;

    src_beat_t src_q[M][$];
    obs_t      beats[$];
    cpl_t      cpls[$];

    int n_vec = 0, n_err = 0, cyc = 0, rc_ready_cnt = 0, stall_bad = 0;
    logic rready_toggle = 1'b0;
    logic st_valid = 1'b0;
    logic [IW-1:0] st_id;
    logic [DW-1:0] st_data;
    logic st_last;

    task automatic drive_srcs();
        for (int i = 0; i < M; i++) begin
            bus.int_rvalid[i]             = (src_q[i].size() > 0);
            bus.int_rid[i*IW +: IW]       = (src_q[i].size() > 0) ? src_q[i][0].id : '0;
            bus.int_rdata[i*DW +: DW]     = (src_q[i].size() > 0) ? src_q[i][0].data : '0;
            bus.int_rlast[i]              = (src_q[i].size() > 0) ? src_q[i][0].last : 1'b0;
            bus.int_rresp[i*2 +: 2]       = 2'b00;
        end
    endtask

    task automatic load(input int m, input logic [IW-1:0] id, input logic [DW-1:0] base, input int n);
        for (int j = 0; j < n; j++) src_q[m].push_back('{id, base + DW'(j), (j == n - 1)});
        drive_srcs();
    endtask

    // One clock: sample at negedge, advance stimulus just after posedge
    task automatic step();
        logic [M-1:0] fire;
        logic rcr;
        @(negedge clk);
        cyc++;
        fire = bus.int_rvalid & bus.int_rready;
        if (st_valid && (bus.s_axi_rvalid !== 1'b1 || bus.s_axi_rid !== st_id ||
                         bus.s_axi_rdata !== st_data || bus.s_axi_rlast !== st_last))
            stall_bad++;
        st_valid = bus.s_axi_rvalid && !bus.s_axi_rready;
        st_id = bus.s_axi_rid; st_data = bus.s_axi_rdata; st_last = bus.s_axi_rlast;
        if (bus.s_axi_rvalid && bus.s_axi_rready)
            beats.push_back('{bus.s_axi_rid, bus.s_axi_rdata, bus.s_axi_rresp, bus.s_axi_rlast, cyc});
        if (bus.m_cpl_valid) cpls.push_back('{bus.m_cpl_id, cyc});
        if (bus.s_rc_ready) rc_ready_cnt++;
        rcr = bus.s_rc_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < M; i++) if (fire[i]) void'(src_q[i].pop_front());
        if (rcr) bus.s_rc_valid = 1'b0;
        bus.s_axi_rready = rready_toggle ? ~bus.s_axi_rready : 1'b1;
        drive_srcs();
    endtask

    task automatic run(input int nbeats, input int budget, output bit ok);
        int n = 0;
        while (beats.size() < nbeats && n < budget) begin step(); n++; end
        ok = (beats.size() >= nbeats);
        repeat (3) step();
    endtask

    task automatic test_reset();
        bus.s_rc_id = '0; bus.s_rc_len = '0; bus.s_rc_decerr = 1'b0; bus.s_rc_valid = 1'b0;
        bus.int_ruser = '0; bus.s_axi_rready = 1'b1;
        drive_srcs();
        repeat (3) @(negedge clk);
        n_vec += 6;
        if (bus.s_axi_rvalid !== 1'b0) begin n_err++; $display("FAIL reset_rvalid got %b want 0", bus.s_axi_rvalid); end
        if (bus.s_axi_rid !== '0 || bus.s_axi_rdata !== '0 || bus.s_axi_rlast !== 1'b0) begin
            n_err++; $display("FAIL reset_payload got id %h data %h last %b want 0", bus.s_axi_rid, bus.s_axi_rdata, bus.s_axi_rlast); end
        if (bus.int_rready !== '0) begin n_err++; $display("FAIL reset_int_rready got %b want 0", bus.int_rready); end
        if (bus.s_rc_ready !== 1'b0) begin n_err++; $display("FAIL reset_rc_ready got %b want 0", bus.s_rc_ready); end
        if (bus.m_cpl_valid !== 1'b0) begin n_err++; $display("FAIL reset_cpl_valid got %b want 0", bus.m_cpl_valid); end
        if (bus.m_cpl_id !== '0) begin n_err++; $display("FAIL reset_cpl_id got %h want 0", bus.m_cpl_id); end
        @(posedge clk); #1; rst = 1'b0;
        step();
    endtask

    task automatic test_contention();
        logic [IW-1:0] eid [6] = '{8'h20, 8'h20, 8'h22, 8'h22, 8'h21, 8'h21};
        logic [DW-1:0] ed  [6] = '{32'h100, 32'h101, 32'h200, 32'h201, 32'h110, 32'h111};
        logic          el  [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        bit ok;
        beats.delete(); cpls.delete();
        load(0, 8'h20, 32'h100, 2);
        load(0, 8'h21, 32'h110, 2);
        load(2, 8'h22, 32'h200, 2);
        run(6, 60, ok);
        n_vec++;
        if (!ok || beats.size() != 6) begin n_err++; $display("FAIL contention_count got %0d want 6", beats.size()); end
        for (int j = 0; j < 6; j++) begin
            n_vec++;
            if (beats[j].id !== eid[j] || beats[j].data !== ed[j] || beats[j].last !== el[j]) begin
                n_err++; $display("FAIL contention_beat%0d got id %h data %h last %b want id %h data %h last %b",
                                  j, beats[j].id, beats[j].data, beats[j].last, eid[j], ed[j], el[j]); end
        end
        n_vec++;
        if (beats[2].cyc - beats[1].cyc !== 2) begin
            n_err++; $display("FAIL contention_gap got %0d want 2", beats[2].cyc - beats[1].cyc); end
        n_vec++;
        if (cpls.size() != 3 || cpls[0].id !== 8'h20 || cpls[1].id !== 8'h22 || cpls[2].id !== 8'h21) begin
            n_err++; $display("FAIL contention_cpl got n=%0d ids %h %h %h want 3 ids 20 22 21",
                              cpls.size(), cpls[0].id, cpls[1].id, cpls[2].id); end
    endtask

    task automatic test_single();
        int t0;
        bit ok;
        beats.delete(); cpls.delete();
        load(1, 8'h12, 32'hA0, 4);
        t0 = cyc;
        run(4, 30, ok);
        n_vec++;
        if (!ok || beats.size() != 4) begin n_err++; $display("FAIL single_count got %0d want 4", beats.size()); end
        n_vec++;
        if (beats[0].cyc !== t0 + 3) begin n_err++; $display("FAIL single_latency got %0d want %0d", beats[0].cyc - t0, 3); end
        for (int j = 0; j < 4; j++) begin
            n_vec++;
            if (beats[j].id !== 8'h12 || beats[j].data !== 32'hA0 + j || beats[j].resp !== 2'b00 ||
                beats[j].last !== (j == 3)) begin
                n_err++; $display("FAIL single_beat%0d got id %h data %h last %b want id 12 data %h last %b",
                                  j, beats[j].id, beats[j].data, beats[j].last, 32'hA0 + j, (j == 3)); end
        end
        n_vec++;
        if (cpls.size() != 1 || cpls[0].id !== 8'h12 || cpls[0].cyc !== beats[3].cyc + 1) begin
            n_err++; $display("FAIL single_cpl got n=%0d id %h at +%0d want 1 id 12 at +1",
                              cpls.size(), cpls[0].id, cpls[0].cyc - beats[3].cyc); end
    endtask

    task automatic test_decerr();
        int t0, rc0;
        bit ok;
        beats.delete(); cpls.delete();
        rc0 = rc_ready_cnt;
        bus.s_rc_id = 8'h05; bus.s_rc_len = 8'd3; bus.s_rc_decerr = 1'b1; bus.s_rc_valid = 1'b1;
        t0 = cyc;
        run(4, 30, ok);
        n_vec++;
        if (!ok || beats.size() != 4) begin n_err++; $display("FAIL decerr_count got %0d want 4", beats.size()); end
        n_vec++;
        if (beats[0].cyc !== t0 + 4) begin n_err++; $display("FAIL decerr_latency got %0d want 4", beats[0].cyc - t0); end
        for (int j = 0; j < 4; j++) begin
            n_vec++;
            if (beats[j].id !== 8'h05 || beats[j].data !== '0 || beats[j].resp !== 2'b11 || beats[j].last !== (j == 3)) begin
                n_err++; $display("FAIL decerr_beat%0d got id %h data %h resp %b last %b want id 05 data 0 resp 11 last %b",
                                  j, beats[j].id, beats[j].data, beats[j].resp, beats[j].last, (j == 3)); end
        end
        n_vec++;
        if (rc_ready_cnt - rc0 !== 1) begin n_err++; $display("FAIL decerr_rc_ready got %0d pulses want 1", rc_ready_cnt - rc0); end
        n_vec++;
        if (cpls.size() != 0) begin n_err++; $display("FAIL decerr_no_cpl got %0d want 0", cpls.size()); end
    endtask

    task automatic test_decerr_long();
        int nlast = 0, nbad = 0;
        bit ok;
        beats.delete(); cpls.delete();
        bus.s_rc_id = 8'h07; bus.s_rc_len = 8'd255; bus.s_rc_decerr = 1'b1; bus.s_rc_valid = 1'b1;
        run(256, 400, ok);
        repeat (4) step();
        foreach (beats[j]) begin
            if (beats[j].last) nlast++;
            if (beats[j].id !== 8'h07 || beats[j].resp !== 2'b11 || beats[j].data !== '0) nbad++;
        end
        n_vec++;
        if (!ok || beats.size() != 256) begin n_err++; $display("FAIL decerr256_count got %0d want 256", beats.size()); end
        n_vec++;
        if (nlast !== 1 || beats[255].last !== 1'b1) begin
            n_err++; $display("FAIL decerr256_last got %0d lasts, final %b want 1 on beat 256", nlast, beats[255].last); end
        n_vec++;
        if (nbad !== 0 || cpls.size() != 0) begin
            n_err++; $display("FAIL decerr256_payload got %0d bad beats %0d cpl want 0 0", nbad, cpls.size()); end
    endtask

    task automatic test_backpressure();
        bit ok;
        beats.delete(); cpls.delete();
        stall_bad = 0;
        rready_toggle = 1'b1;
        load(3, 8'h33, 32'h300, 8);
        run(8, 80, ok);
        rready_toggle = 1'b0;
        repeat (3) step();
        n_vec++;
        if (!ok || beats.size() != 8) begin n_err++; $display("FAIL bp_count got %0d want 8", beats.size()); end
        for (int j = 0; j < 8; j++) begin
            n_vec++;
            if (beats[j].id !== 8'h33 || beats[j].data !== 32'h300 + j || beats[j].last !== (j == 7)) begin
                n_err++; $display("FAIL bp_beat%0d got id %h data %h last %b want id 33 data %h last %b",
                                  j, beats[j].id, beats[j].data, beats[j].last, 32'h300 + j, (j == 7)); end
        end
        n_vec++;
        if (stall_bad !== 0) begin n_err++; $display("FAIL bp_stable got %0d changes want 0", stall_bad); end
        n_vec++;
        if (cpls.size() != 1 || cpls[0].id !== 8'h33) begin
            n_err++; $display("FAIL bp_cpl got n=%0d id %h want 1 id 33", cpls.size(), cpls[0].id); end
    endtask

    task automatic test_reset_midburst();
        int n = 0;
        bit ok;
        beats.delete(); cpls.delete();
        load(1, 8'h41, 32'h400, 4);
        while (beats.size() < 2 && n < 20) begin step(); n++; end
        n_vec++;
        if (beats.size() != 2 || bus.s_axi_rvalid !== 1'b1) begin
            n_err++; $display("FAIL rstmid_setup got %0d beats rvalid %b want 2 1", beats.size(), bus.s_axi_rvalid); end
        #2 rst = 1'b1;
        #1;
        n_vec++;
        if (bus.s_axi_rvalid !== 1'b0 || bus.int_rready !== '0 || bus.m_cpl_id !== '0) begin
            n_err++; $display("FAIL rstmid_async got rvalid %b rready %b cpl_id %h want 0 0 0",
                              bus.s_axi_rvalid, bus.int_rready, bus.m_cpl_id); end
        for (int i = 0; i < M; i++) src_q[i].delete();
        drive_srcs();
        beats.delete();
        repeat (4) step();
        rst = 1'b0;
        step();
        n_vec++;
        if (cpls.size() != 0 || beats.size() != 0) begin
            n_err++; $display("FAIL rstmid_dropped got %0d cpl %0d beats want 0 0", cpls.size(), beats.size()); end
        load(0, 8'h50, 32'h500, 1);
        load(3, 8'h53, 32'h530, 1);
        run(2, 20, ok);
        n_vec++;
        if (!ok || beats[0].id !== 8'h50 || beats[1].id !== 8'h53) begin
            n_err++; $display("FAIL rstmid_order got ids %h %h want 50 53", beats[0].id, beats[1].id); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_contention();
        test_single();
        test_decerr();
        test_decerr_long();
        test_backpressure();
        test_reset_midburst();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/axi_crossbar_rresp.md
# axi_crossbar_rresp

Read-response return path for one slave interface of the AXI crossbar. Merges the R-channel streams from all master interfaces with a local decode-error responder, using burst-locked round-robin arbitration. Reports completed bursts back to the address-decode/admission block as completion events (ID + valid), so that block can retire transaction and thread counts. Sits between the per-master R channels and the slave-side R output register.

## Interface
- M_COUNT, 4: number of master interfaces (R sources), ≥1
- DATA_WIDTH, 32: R data width
- ID_WIDTH, 8: ID width
- RUSER_ENABLE, 0: propagate ruser when 1, else drive 0
- RUSER_WIDTH, 1: ruser width

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- s_rc_id  in  ID_WIDTH  ID of decode-error read
- s_rc_len  in  8  arlen of decode-error read
- s_rc_decerr  in  1  command is a decode error (must be 1 when s_rc_valid)
- s_rc_valid  in  1  reply command valid
- s_rc_ready  out  1  reply command accepted
- int_rid  in  M_COUNT*ID_WIDTH  per-master R id
- int_rdata  in  M_COUNT*DATA_WIDTH  per-master R data
- int_rresp  in  M_COUNT*2  per-master R resp
- int_rlast  in  M_COUNT  per-master R last
- int_ruser  in  M_COUNT*RUSER_WIDTH  per-master R user
- int_rvalid  in  M_COUNT  per-master R valid
- int_rready  out  M_COUNT  per-master R ready
- s_axi_rid / rdata / rresp / rlast / ruser  out  ID_WIDTH / DATA_WIDTH / 2 / 1 / RUSER_WIDTH  slave R payload
- s_axi_rvalid  out  1  slave R valid
- s_axi_rready  in  1  slave R ready
- m_cpl_id  out  ID_WIDTH  completed burst ID
- m_cpl_valid  out  1  completion pulse

## Operation
- Requesters 0..M_COUNT-1 = int_* sources; requester M_COUNT = decerr responder.
- Decerr responder states: IDLE, ACTIVE. In IDLE with s_rc_valid: capture id, len into regs, pulse s_rc_ready for 1 cycle, go ACTIVE. In ACTIVE it presents beats: rid = captured id, rdata = 0, rresp = 2'b11, ruser = 0, rlast when beat counter == len. Counter is 8-bit, reset to 0 on capture, incremented per accepted beat. After the rlast beat is accepted, return to IDLE. len = 255 gives 256 beats with no wrap error.
- Arbiter: when unlocked, grant the lowest-index requesting source at or after (last_grant+1) mod (M_COUNT+1) and lock. Lock is held until the granted source's rlast beat is accepted into the output register. The grant is re-evaluated in the following cycle, so there is one arbitration cycle between bursts. Beats of a granted burst are never interleaved with another source.
- Output register: int_rready[g] = lock && grant==g && (!s_axi_rvalid || s_axi_rready); all other int_rready are 0. An accepted beat loads the payload plus a decerr flag into the output register.
- Completion: when a beat with rlast=1 and decerr flag=0 transfers on s_axi (rvalid && rready), the next cycle has m_cpl_valid=1 for exactly 1 cycle, with m_cpl_id = that rid. Decerr bursts produce no completion. Back-to-back completions on consecutive cycles are impossible because of the arbitration gap.

## Timing
- Reset (async assert, sync-safe release): s_axi_rvalid=0, all payload outputs=0, int_rready=0, s_rc_ready=0, m_cpl_valid=0, m_cpl_id=0, lock=0, last_grant=M_COUNT (so source 0 wins first), responder IDLE.
- Reset asserted mid-burst: the burst is dropped, no completion is emitted, and all state returns to reset values immediately.
- Latency: source valid to grant is 1 cycle. Grant to first s_axi_rvalid is 1 cycle. Sustained throughput within a burst is 1 beat/cycle while s_axi_rready=1.
- Backpressure: s_axi_rready=0 holds the payload stable and deasserts int_rready.
- s_rc_valid from command to first decerr beat on s_axi: ≥3 cycles (capture, arbitrate, register).

## Test plan
- Single master 1, 4-beat burst, id 0x12, rready=1 -> 4 beats in order, rlast on beat 4, m_cpl_valid pulse with id 0x12 the cycle after beat 4.
- Masters 0 and 2 both valid with 2-beat bursts -> all of burst 0 then all of burst 2 (no interleave). Next contention with 0 and 2 -> 2 wins.
- Decerr: s_rc_id=0x5, s_rc_len=3 -> s_rc_ready pulses once, then 4 beats with rresp=2'b11, rdata=0, rlast on beat 4, and no m_cpl_valid.
- Decerr with s_rc_len=255 -> exactly 256 beats, rlast only on the last beat.
- s_axi_rready toggled 1/0 every cycle during an 8-beat burst -> no beat lost or duplicated, and payload stable while stalled.
- rst asserted mid-burst (beat 2 of 4) -> s_axi_rvalid=0 immediately and no completion. After release, a new burst from source 0 is granted first.
